// File: rtl/seg7_scan_mux_if.sv
// Display-driver bundle: value/config inputs toward the scanner, segment and digit-select pins back.
// master = datapath side, slave = seg7_scan_mux.
interface seg7_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                En;
  logic                enSet;
  logic [DIGITS-1:0]   blinkMask;
  logic                hexMode;
  logic                blankLZ;
  logic [0:6]          out;
  logic [DIGITS-1:0]   an;

  modport master (
    output value, load, En, enSet, blinkMask, hexMode, blankLZ,
    input  out, an
  );

  modport slave (
    input  value, load, En, enSet, blinkMask, hexMode, blankLZ,
    output out, an
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed 7-seg driver with double-buffered value, hex/LZ/blink, dead time.
// out/an registered 1 clk after scan state; no backpressure, load is accepted every cycle.
module seg7_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 100
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_mux_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0]     SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     DEAD_C     = CW'(DEAD);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0]     FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] ONE_HOT0   = DIGITS'(1);

  logic [CW-1:0]       scan_cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       frame_cnt;
  logic                blink_phase;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] disp;
  logic [0:6]          out_q;
  logic [DIGITS-1:0]   an_q;

  logic                scan_tc;
  logic                frame_bnd;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_above;
  logic                cur_blank;

  function automatic logic [0:6] decode(input logic [3:0] d, input logic hex);
    logic [0:6] seg;
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      4'd10:   seg = hex ? 7'b0001000 : 7'b1111110;
      4'd11:   seg = hex ? 7'b1100000 : 7'b1111110;
      4'd12:   seg = hex ? 7'b0110001 : 7'b1111110;
      4'd13:   seg = hex ? 7'b1000010 : 7'b1111110;
      4'd14:   seg = hex ? 7'b0110000 : 7'b1111110;
      default: seg = hex ? 7'b0111000 : 7'b1111110;
    endcase
    return seg;
  endfunction

  assign scan_tc   = (scan_cnt == SCAN_LAST);
  assign frame_bnd = scan_tc && (idx == IDX_LAST);
  assign cur_nib   = disp[{idx, 2'b00} +: 4];

  // lz_mask[i]: nibbles i..DIGITS-1 are all zero; digit 0 never qualifies.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (disp[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_above;
    end
  end

  assign cur_blank = !bus.En
                   || (bus.blankLZ && lz_mask[idx])
                   || (bus.enSet && bus.blinkMask[idx] && blink_phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      shadow      <= '0;
      disp        <= '0;
      out_q       <= '1;
      an_q        <= '1;
    end else begin
      if (scan_tc) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      // Display copy only moves at the frame boundary, so a frame never mixes two values.
      if (frame_bnd) begin
        disp <= shadow;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= !blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      if (bus.load) begin
        shadow <= bus.value;
      end

      out_q <= cur_blank ? 7'b1111111 : decode(cur_nib, bus.hexMode);
      an_q  <= (bus.En && (scan_cnt >= DEAD_C)) ? ~(ONE_HOT0 << idx) : '1;
    end
  end

  assign bus.out = out_q;
  assign bus.an  = an_q;
endmodule
